// File: rtl/bmult_accumulator_if.sv
// Handshake bundle between the operand issuer / product source and the
// accumulator: issue tags, product, and the valid/ready result port.
interface bmult_accumulator_if #(
  parameter int WIDTH = 32,
  parameter int GUARD = 8
);
  localparam int ACC_W = 2 * WIDTH + GUARD;

  logic               in_valid;
  logic               in_first;
  logic               in_last;
  logic               in_ready;
  logic [2*WIDTH-1:0] p;
  logic [ACC_W-1:0]   acc_data;
  logic               acc_ovf;
  logic               acc_valid;
  logic               acc_ready;

  modport master (
    output in_valid, in_first, in_last, p, acc_ready,
    input  in_ready, acc_data, acc_ovf, acc_valid
  );

  modport slave (
    input  in_valid, in_first, in_last, p, acc_ready,
    output in_ready, acc_data, acc_ovf, acc_valid
  );
endinterface

// File: rtl/bmult_accumulator.sv
// Framed accumulator for a pipelined multiplier product: tag delay line,
// guarded sum with sticky overflow, and a 2-entry result buffer.
module bmult_accumulator #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 1,
  parameter int GUARD    = 8
) (
  input  logic              clk,
  input  logic              rst,
  bmult_accumulator_if.slave io_bus
);
  localparam int ACC_W = 2 * WIDTH + GUARD;
  localparam int CW    = $clog2(MULT_LAT + 1) + 1;

  logic [MULT_LAT-1:0] r_tag_v;
  logic [MULT_LAT-1:0] r_tag_f;
  logic [MULT_LAT-1:0] r_tag_l;
  logic [ACC_W-1:0]    r_acc;
  logic                r_ovf;
  logic [ACC_W-1:0]    r_mem_d [2];
  logic [1:0]          r_mem_o;
  logic                r_rd_ptr;
  logic                r_wr_ptr;
  logic [1:0]          r_count;

  logic                w_accept;
  logic                w_al_v;
  logic                w_al_f;
  logic                w_al_l;
  logic                w_push;
  logic                w_pop;
  logic                w_valid;
  logic [ACC_W:0]      w_sum;
  logic                w_ovf_next;
  logic [CW-1:0]       w_last_cnt;
  logic [CW-1:0]       w_free;

  // Every last tag still in flight will claim a buffer slot when it lands.
  always_comb begin
    w_last_cnt = '0;
    for (int i = 0; i < MULT_LAT; i++) begin
      w_last_cnt = w_last_cnt + CW'(r_tag_v[i] & r_tag_l[i]);
    end
  end

  assign w_free          = CW'(2'd2 - r_count);
  assign io_bus.in_ready = (w_free > w_last_cnt);
  assign w_accept        = io_bus.in_valid & io_bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_v <= '0;
      r_tag_f <= '0;
      r_tag_l <= '0;
    end else begin
      r_tag_v[0] <= w_accept;
      r_tag_f[0] <= w_accept & io_bus.in_first;
      r_tag_l[0] <= w_accept & io_bus.in_last;
      for (int i = 1; i < MULT_LAT; i++) begin
        r_tag_v[i] <= r_tag_v[i-1];
        r_tag_f[i] <= r_tag_f[i-1];
        r_tag_l[i] <= r_tag_l[i-1];
      end
    end
  end

  assign w_al_v = r_tag_v[MULT_LAT-1];
  assign w_al_f = w_al_v & r_tag_f[MULT_LAT-1];
  assign w_al_l = w_al_v & r_tag_l[MULT_LAT-1];

  assign w_sum      = (w_al_f ? '0 : {1'b0, r_acc})
                    + {{(ACC_W + 1 - 2 * WIDTH){1'b0}}, io_bus.p};
  assign w_ovf_next = (w_al_f ? 1'b0 : r_ovf) | w_sum[ACC_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (w_al_v) begin
      if (w_al_l) begin
        r_acc <= '0;
        r_ovf <= 1'b0;
      end else begin
        r_acc <= w_sum[ACC_W-1:0];
        r_ovf <= w_ovf_next;
      end
    end
  end

  assign w_push  = w_al_l;
  assign w_valid = (r_count != 2'd0);
  assign w_pop   = w_valid & io_bus.acc_ready;

  // On a full buffer with a simultaneous pop, the write lands in the slot
  // being vacated, so occupancy stays at two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_d[0] <= '0;
      r_mem_d[1] <= '0;
      r_mem_o    <= '0;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem_d[r_wr_ptr] <= w_sum[ACC_W-1:0];
        r_mem_o[r_wr_ptr] <= w_ovf_next;
        r_wr_ptr          <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign io_bus.acc_valid = w_valid;
  assign io_bus.acc_data  = w_valid ? r_mem_d[r_rd_ptr] : '0;
  assign io_bus.acc_ovf   = w_valid & r_mem_o[r_rd_ptr];
endmodule

// File: tb/tb_bmult_accumulator.sv
// Bench for bmult_accumulator: one instance with MULT_LAT=1/GUARD=8, one with
// MULT_LAT=3/GUARD=0; expected frame sums queue up at issue, compared at pop.
module tb_bmult_accumulator;
  localparam logic [63:0] GARBAGE = 64'hA5A5_5A5A_DEAD_BEEF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bmult_accumulator_if #(.WIDTH(32), .GUARD(8)) bus_a ();
  bmult_accumulator_if #(.WIDTH(32), .GUARD(0)) bus_b ();

  bmult_accumulator #(.WIDTH(32), .MULT_LAT(1), .GUARD(8)) u_a (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus_a.slave)
  );

  bmult_accumulator #(.WIDTH(32), .MULT_LAT(3), .GUARD(0)) u_b (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus_b.slave)
  );

  // Multiplier stand-in: the product of an accepted issue appears MULT_LAT
  // clocks later; otherwise p carries junk that must be ignored.
  logic [63:0] prod_a, prod_b;
  logic [63:0] pipe_a;
  logic [63:0] pipe_b [3];

  always @(posedge clk) begin
    pipe_a    <= (bus_a.in_valid && bus_a.in_ready) ? prod_a : GARBAGE;
    pipe_b[0] <= (bus_b.in_valid && bus_b.in_ready) ? prod_b : GARBAGE;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign bus_a.p = pipe_a;
  assign bus_b.p = pipe_b[2];

  typedef struct packed {
    logic [71:0] d;
    logic        o;
  } res_t;

  typedef struct packed {
    logic [63:0] prod;
    logic        f;
    logic        l;
    logic [71:0] ed;
    logic        eo;
  } vec_t;

  res_t q_a[$];
  res_t q_b[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void check(input string nm, input logic [71:0] act,
                                input logic [71:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [63:0] mul(input logic [31:0] a, input logic [31:0] b);
    return {32'd0, a} * {32'd0, b};
  endfunction

  always @(negedge clk) begin
    res_t e;
    if (!rst && bus_a.acc_valid && bus_a.acc_ready) begin
      if (q_a.size() == 0) begin
        check("a_unexpected_out", {8'd0, bus_a.acc_data}, 72'hFFFF);
      end else begin
        e = q_a.pop_front();
        check("a_acc_data", {8'd0, bus_a.acc_data}, e.d);
        check("a_acc_ovf", {71'd0, bus_a.acc_ovf}, {71'd0, e.o});
      end
    end
    if (!rst && bus_b.acc_valid && bus_b.acc_ready) begin
      if (q_b.size() == 0) begin
        check("b_unexpected_out", {8'd0, bus_b.acc_data}, 72'hFFFF);
      end else begin
        e = q_b.pop_front();
        check("b_acc_data", {8'd0, bus_b.acc_data}, e.d);
        check("b_acc_ovf", {71'd0, bus_b.acc_ovf}, {71'd0, e.o});
      end
    end
  end

  task automatic idle(input bit sel);
    if (sel == 1'b0) begin
      bus_a.in_valid = 1'b0; bus_a.in_first = 1'b0; bus_a.in_last = 1'b0;
      prod_a = GARBAGE;
    end else begin
      bus_b.in_valid = 1'b0; bus_b.in_first = 1'b0; bus_b.in_last = 1'b0;
      prod_b = GARBAGE;
    end
  endtask

  // Holds the item until accepted; returns 1 time unit after the accepting edge.
  task automatic issue(input bit sel, input logic [63:0] prod, input logic f,
                       input logic l, input logic [71:0] ed, input logic eo);
    bit done   = 1'b0;
    int budget = 0;
    res_t r;
    r.d = ed;
    r.o = eo;
    if (sel == 1'b0) begin
      bus_a.in_valid = 1'b1; bus_a.in_first = f; bus_a.in_last = l; prod_a = prod;
    end else begin
      bus_b.in_valid = 1'b1; bus_b.in_first = f; bus_b.in_last = l; prod_b = prod;
    end
    while (!done) begin
      @(negedge clk);
      if ((sel == 1'b0) ? bus_a.in_ready : bus_b.in_ready) begin
        done = 1'b1;
        if (l) begin
          if (sel == 1'b0) q_a.push_back(r);
          else             q_b.push_back(r);
        end
      end else if (budget++ > 200) begin
        check("issue_timeout", 72'd0, 72'd1);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tab [11];
    tab[0]  = '{mul(3, 5),                     1'b1, 1'b0, 72'd0, 1'b0};
    tab[1]  = '{mul(7, 9),                     1'b0, 1'b0, 72'd0, 1'b0};
    tab[2]  = '{mul(2, 2),                     1'b0, 1'b1, 72'd82, 1'b0};
    tab[3]  = '{mul(32'hFFFFFFFF, 32'hFFFFFFFF), 1'b1, 1'b1, 72'h00_FFFF_FFFE_0000_0001, 1'b0};
    tab[4]  = '{mul(6, 7),                     1'b0, 1'b1, 72'd42, 1'b0};
    tab[5]  = '{mul(100, 200),                 1'b1, 1'b0, 72'd0, 1'b0};
    tab[6]  = '{mul(0, 5),                     1'b0, 1'b1, 72'd20000, 1'b0};
    tab[7]  = '{mul(9, 9),                     1'b1, 1'b1, 72'd81, 1'b0};
    tab[8]  = '{mul(32'hFFFFFFFF, 32'hFFFFFFFF), 1'b1, 1'b0, 72'd0, 1'b0};
    tab[9]  = '{mul(32'hFFFFFFFF, 32'hFFFFFFFF), 1'b0, 1'b0, 72'd0, 1'b0};
    tab[10] = '{mul(1, 1),                     1'b0, 1'b1, 72'h01_FFFF_FFFC_0000_0003, 1'b0};

    rst = 1'b0;
    idle(0);
    idle(1);
    bus_a.acc_ready = 1'b1;
    bus_b.acc_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("rst_a_valid", {71'd0, bus_a.acc_valid}, 72'd0);
    check("rst_a_data", {8'd0, bus_a.acc_data}, 72'd0);
    check("rst_a_ovf", {71'd0, bus_a.acc_ovf}, 72'd0);
    check("rst_b_valid", {71'd0, bus_b.acc_valid}, 72'd0);
    check("rst_b_data", {8'd0, bus_b.acc_data}, 72'd0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_a_in_ready", {71'd0, bus_a.in_ready}, 72'd1);
    check("rst_b_in_ready", {71'd0, bus_b.in_ready}, 72'd1);

    for (int i = 0; i < 11; i++) begin
      issue(0, tab[i].prod, tab[i].f, tab[i].l, tab[i].ed, tab[i].eo);
    end
    idle(0);
    repeat (6) @(posedge clk);
    #1;

    // last issue at cycle t -> acc_valid only in cycle t+2 (MULT_LAT=1)
    issue(0, mul(3, 5), 1'b1, 1'b0, 72'd0, 1'b0);
    issue(0, mul(7, 9), 1'b0, 1'b0, 72'd0, 1'b0);
    issue(0, mul(2, 2), 1'b0, 1'b1, 72'd82, 1'b0);
    idle(0);
    @(negedge clk);
    check("lat_t1_valid", {71'd0, bus_a.acc_valid}, 72'd0);
    @(negedge clk);
    check("lat_t2_valid", {71'd0, bus_a.acc_valid}, 72'd1);
    @(negedge clk);
    check("lat_t3_valid", {71'd0, bus_a.acc_valid}, 72'd0);
    @(posedge clk);
    #1;

    // Back-pressure: two results fill the buffer, third issue is held.
    bus_a.acc_ready = 1'b0;
    issue(0, 64'd1, 1'b1, 1'b1, 72'd1, 1'b0);
    issue(0, 64'd2, 1'b1, 1'b1, 72'd2, 1'b0);
    bus_a.in_valid = 1'b1; bus_a.in_first = 1'b1; bus_a.in_last = 1'b1; prod_a = 64'd3;
    repeat (4) begin
      @(negedge clk);
      check("bp_in_ready", {71'd0, bus_a.in_ready}, 72'd0);
      check("bp_valid", {71'd0, bus_a.acc_valid}, 72'd1);
      check("bp_head_stable", {8'd0, bus_a.acc_data}, 72'd1);
    end
    @(posedge clk);
    #1;
    bus_a.acc_ready = 1'b1;
    issue(0, 64'd3, 1'b1, 1'b1, 72'd3, 1'b0);
    idle(0);
    repeat (6) @(posedge clk);
    #1;

    // MULT_LAT=3, GUARD=0: overflow, sticky ovf, back-to-back frames.
    issue(1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 72'd0, 1'b0);
    issue(1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 72'h00_FFFF_FFFF_FFFF_FFFE, 1'b1);
    issue(1, 64'd5,  1'b1, 1'b0, 72'd0, 1'b0);
    issue(1, 64'd6,  1'b0, 1'b1, 72'd11, 1'b0);
    issue(1, 64'd10, 1'b1, 1'b0, 72'd0, 1'b0);
    issue(1, 64'd20, 1'b0, 1'b0, 72'd0, 1'b0);
    issue(1, 64'd30, 1'b0, 1'b1, 72'd60, 1'b0);
    issue(1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 72'd0, 1'b0);
    issue(1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 72'd0, 1'b0);
    issue(1, 64'd1,  1'b0, 1'b1, 72'h00_FFFF_FFFF_FFFF_FFFF, 1'b1);
    issue(1, 64'd7,  1'b1, 1'b1, 72'd7, 1'b0);
    idle(1);
    repeat (10) @(posedge clk);
    #1;
    check("b_drained", 72'(q_b.size()), 72'd0);

    // Reset with a buffered result, a partial sum and a tag in flight.
    bus_a.acc_ready = 1'b0;
    issue(0, 64'd7,   1'b1, 1'b1, 72'd7, 1'b0);
    issue(0, 64'd100, 1'b1, 1'b0, 72'd0, 1'b0);
    issue(0, 64'd200, 1'b0, 1'b0, 72'd0, 1'b0);
    idle(0);
    #1;
    check("pre_rst_valid", {71'd0, bus_a.acc_valid}, 72'd1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_valid", {71'd0, bus_a.acc_valid}, 72'd0);
    check("async_rst_data", {8'd0, bus_a.acc_data}, 72'd0);
    check("async_rst_ovf", {71'd0, bus_a.acc_ovf}, 72'd0);
    q_a.delete();
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    bus_a.acc_ready = 1'b1;
    issue(0, 64'd16, 1'b0, 1'b1, 72'd16, 1'b0);
    issue(0, mul(4, 4), 1'b1, 1'b1, 72'd16, 1'b0);
    idle(0);
    repeat (8) @(posedge clk);
    #1;
    check("a_drained", 72'(q_a.size()), 72'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
